sar_sequencer: RTL and testbench

SAR_SEQUENCER -- requirements
Module: sar_sequencer

---
 rtl/sar_seq_pkg.sv | 36 +++
 rtl/sar_seq_if.sv | 34 +++
 rtl/sar_seq_fifo.sv | 59 +++++
 rtl/sar_sequencer.sv | 143 ++++++++++++++
 tb/tb_sar_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_seq_pkg.sv
// SAR sequencer shared definitions:
// FSM state codes, OSR codes, datapath widths and helpers.
package sar_seq_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 11;
  localparam int CNT_W  = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ISSUE     = 3'd1;
  localparam state_t S_WAIT      = 3'd2;
  localparam state_t S_ACCUM     = 3'd3;
  localparam state_t S_CAL_ISSUE = 3'd4;
  localparam state_t S_CAL_WAIT  = 3'd5;

  localparam logic [1:0] OSR_1 = 2'd0;
  localparam logic [1:0] OSR_2 = 2'd1;
  localparam logic [1:0] OSR_4 = 2'd2;
  localparam logic [1:0] OSR_8 = 2'd3;

  function automatic logic [CNT_W-1:0] osr_n(
    input logic [1:0] code
  );
    return CNT_W'(1) << code;
  endfunction

  function automatic logic [DATA_W-1:0] avg_of(
    input logic [ACC_W-1:0] acc,
    input logic [1:0]       code
  );
    return DATA_W'(acc >> code);
  endfunction

endpackage

// File: rtl/sar_seq_if.sv
// SAR sequencer bus: conversion handshake toward the SAR
// logic and the averaged-sample output stream.
interface sar_seq_if;
  import sar_seq_pkg::*;

  logic              adc_en;
  logic              adc_cal;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output adc_en,
    output adc_cal,
    input  adc_valid,
    input  adc_result,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    input  adc_en,
    input  adc_cal,
    output adc_valid,
    output adc_result,
    input  out_valid,
    output out_ready,
    input  out_data
  );

endinterface

// File: rtl/sar_seq_fifo.sv
// Output FIFO for averaged samples with a registered head
// word; a push into an empty FIFO appears one cycle later.
module sar_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  import sar_seq_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      left;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_rd  = pop & ~empty;
  assign do_wr  = push & (~full | do_rd);
  assign rd_nxt = rd_ptr + AW'(do_rd);
  assign left   = count - (AW+1)'(do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= left + (AW+1)'(do_wr);
      // head must track the entry that will be oldest after this cycle
      if (left == '0) begin
        if (do_wr) head <= din;
      end else begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: oversampled averaging, comparator
// trim calibration, timeout abort and output FIFO.
module sar_sequencer
  import sar_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 63,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       cal_req,
  input  logic [1:0] osr,
  input  logic       flag_clr,
  sar_seq_if.master  bus,
  output logic       busy,
  output logic       cal_done,
  output logic       overrun,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         osr_q;
  logic [TW-1:0]      tcnt;
  logic               cal_pend;
  logic               waiting;
  logic               tmo_hit;
  logic               tmo_evt;
  logic               done;
  logic               pop;
  logic               full;
  logic               empty;
  logic               ovr_evt;
  logic [DATA_W-1:0]  avg;
  logic [DATA_W-1:0]  head;

  assign waiting = (state == S_WAIT) || (state == S_CAL_WAIT);
  assign tmo_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign tmo_evt = waiting & ~bus.adc_valid & tmo_hit;
  assign done    = (state == S_ACCUM) && (cnt == osr_n(osr_q));
  assign avg     = avg_of(acc, osr_q);
  assign pop     = bus.out_valid & bus.out_ready;
  assign ovr_evt = done & full & ~pop;

  assign bus.adc_en    = (state == S_ISSUE) || (state == S_CAL_ISSUE);
  assign bus.adc_cal   = (state == S_CAL_ISSUE);
  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      osr_q    <= OSR_1;
      tcnt     <= '0;
      cal_pend <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      if (cal_req) cal_pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (cal_pend | cal_req) begin
            cal_pend <= 1'b0;
            state    <= S_CAL_ISSUE;
          end else if (run) begin
            osr_q <= osr;
            acc   <= '0;
            cnt   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.adc_valid) begin
            acc   <= acc + ACC_W'(bus.adc_result);
            cnt   <= cnt + CNT_W'(1);
            state <= S_ACCUM;
          end else if (tmo_hit) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_ACCUM: begin
          state <= done ? S_IDLE : S_ISSUE;
        end
        S_CAL_ISSUE: begin
          tcnt  <= '0;
          state <= S_CAL_WAIT;
        end
        S_CAL_WAIT: begin
          if (bus.adc_valid) begin
            cal_done <= 1'b1;
            state    <= S_IDLE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // a flag event in the same cycle as flag_clr keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= ovr_evt | (overrun & ~flag_clr);
      timeout <= tmo_evt | (timeout & ~flag_clr);
    end
  end

  sar_seq_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (done),
    .din   (avg),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer: averaging, calibration,
// timeout, FIFO overrun and asynchronous reset.
module tb_sar_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       run = 1'b0;
  logic       cal_req = 1'b0;
  logic       flag_clr = 1'b0;
  logic [1:0] osr = 2'd0;
  logic       busy;
  logic       cal_done;
  logic       overrun;
  logic       timeout;

  sar_seq_if bus();

  sar_sequencer #(
    .TIMEOUT_CYC (63),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .run      (run),
    .cal_req  (cal_req),
    .osr      (osr),
    .flag_clr (flag_clr),
    .bus      (bus),
    .busy     (busy),
    .cal_done (cal_done),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   en_cnt = 0;
  int   cal_cnt = 0;
  int   en_dbl = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) begin
    if (bus.adc_en) en_cnt <= en_cnt + 1;
    if (bus.adc_cal) cal_cnt <= cal_cnt + 1;
    if (bus.adc_en && en_prev) en_dbl <= en_dbl + 1;
    en_prev <= bus.adc_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input string tag);
    int i;
    i = 0;
    while (!bus.adc_en && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(bus.adc_en), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [7:0] val);
    repeat (dly) @(negedge clk);
    bus.adc_valid  = 1'b1;
    bus.adc_result = val;
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  task automatic pulse_run;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic pop_one;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int         base;
    int         cbase;
    logic [7:0] exp8;

    bus.adc_valid  = 1'b0;
    bus.adc_result = 8'h00;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_adc_en", 32'(bus.adc_en), 32'd0);
    chk("rst_adc_cal", 32'(bus.adc_cal), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_flags", {29'd0, cal_done, overrun, timeout}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single conversion, osr=0
    base = en_cnt;
    osr = 2'd0;
    pulse_run;
    wait_en("t1_en");
    respond(10, 8'hA5);
    @(negedge clk);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_data", 32'(bus.out_data), 32'hA5);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_en_pulses", 32'(en_cnt - base), 32'd1);
    pop_one;
    chk("t1_drained", 32'(bus.out_valid), 32'd0);

    // stray adc_valid while idle
    bus.adc_valid  = 1'b1;
    bus.adc_result = 8'hFF;
    @(negedge clk);
    bus.adc_valid = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_out_valid", 32'(bus.out_valid), 32'd0);

    // osr=2 average of 10..13, osr changed after start
    base = en_cnt;
    osr = 2'd2;
    pulse_run;
    osr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wait_en("t2_en");
      respond(3, 8'(10 + i));
    end
    @(negedge clk);
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_out_data", 32'(bus.out_data), 32'd11);
    chk("t2_en_pulses", 32'(en_cnt - base), 32'd4);
    pop_one;

    // calibration requested twice during an osr=3 average
    base  = en_cnt;
    cbase = cal_cnt;
    osr = 2'd3;
    pulse_run;
    for (int i = 0; i < 8; i++) begin
      wait_en("t3_en");
      if (i == 2 || i == 5) begin
        cal_req = 1'b1;
        @(negedge clk);
        cal_req = 1'b0;
      end
      respond(2, 8'(100 + i));
    end
    chk("t3_en_before_cal", 32'(en_cnt - base), 32'd8);
    chk("t3_no_early_cal", 32'(cal_cnt - cbase), 32'd0);
    wait_en("t3_cal_en");
    chk("t3_adc_cal", 32'(bus.adc_cal), 32'd1);
    respond(4, 8'h33);
    chk("t3_cal_done", 32'(cal_done), 32'd1);
    @(negedge clk);
    chk("t3_cal_done_pulse", 32'(cal_done), 32'd0);
    chk("t3_out_data", 32'(bus.out_data), 32'h67);
    repeat (5) @(negedge clk);
    chk("t3_en_total", 32'(en_cnt - base), 32'd9);
    chk("t3_cal_once", 32'(cal_cnt - cbase), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    pop_one;

    // timeout: no response
    base = en_cnt;
    osr = 2'd0;
    pulse_run;
    wait_en("t4_en");
    repeat (63) @(negedge clk);
    chk("t4_timeout_early", 32'(timeout), 32'd0);
    chk("t4_busy_waiting", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_output", 32'(bus.out_valid), 32'd0);
    chk("t4_en_pulses", 32'(en_cnt - base), 32'd1);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("t4_timeout_clr", 32'(timeout), 32'd0);

    // overrun: five averages into a four-entry FIFO
    base = en_cnt;
    osr = 2'd0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_en("t5_en");
      if (i == 4) run = 1'b0;
      respond(2, 8'(8'h11 * (i + 1)));
      @(negedge clk);
      if (i == 3) chk("t5_no_overrun", 32'(overrun), 32'd0);
    end
    chk("t5_overrun", 32'(overrun), 32'd1);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_en_pulses", 32'(en_cnt - base), 32'd5);
    chk("t5_busy", 32'(busy), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp8 = 8'(8'h11 * (i + 1));
      chk("t5_drain_data", 32'(bus.out_data), 32'(exp8));
      chk("t5_drain_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    chk("t5_drained", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("t5_overrun_clr", 32'(overrun), 32'd0);

    // reset while waiting for a conversion
    osr = 2'd0;
    pulse_run;
    wait_en("t6_en_a");
    respond(2, 8'h5A);
    @(negedge clk);
    chk("t6_fifo_loaded", 32'(bus.out_valid), 32'd1);
    base = en_cnt;
    pulse_run;
    wait_en("t6_en_b");
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_adc_en", 32'(bus.adc_en), 32'd0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.adc_valid  = 1'b1;
    bus.adc_result = 8'h77;
    @(negedge clk);
    bus.adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_late_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_en_pulses", 32'(en_cnt - base), 32'd1);

    chk("no_back_to_back_en", 32'(en_dbl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
